// File: rtl/ctrl_decode_pipe.sv
// ctrl_decode_pipe: decode-stage control decoder feeding a registered
// E-stage control bundle with stall/flush handling.
// Optional feature: define CTRL_ILL_CNT_EN to add the saturating
// illegal-instruction counter and its ill_cnt port.
module ctrl_decode_pipe #(
  parameter int ILL_CNT_W  = 8,
  parameter bit XPROP_ZERO = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          instr_d,
  input  logic                 valid_d,
  input  logic                 stall_e,
  input  logic                 flush_e,
  output logic [2:0]           imm_src_d,
  output logic                 valid_e,
  output logic                 reg_write_e,
  output logic                 mem_write_e,
  output logic                 branch_e,
  output logic                 jump_e,
  output logic                 jalr_e,
  output logic                 alu_src_a_e,
  output logic                 alu_src_b_e,
  output logic                 illegal_e,
  output logic [1:0]           result_src_e,
  output logic [1:0]           alu_op_e,
  output logic [2:0]           funct3_e,
`ifdef CTRL_ILL_CNT_EN
  output logic [ILL_CNT_W-1:0] ill_cnt,
`endif
  output logic                 funct7b5_e
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  typedef struct packed {
    logic       reg_write;
    logic       mem_write;
    logic       branch;
    logic       jump;
    logic       jalr;
    logic       alu_src_a;
    logic       alu_src_b;
    logic [1:0] result_src;
    logic [1:0] alu_op;
    logic       illegal;
    logic [2:0] funct3;
    logic       funct7b5;
  } ctrl_t;

  // Value used for datapath selects an opcode does not care about.
  // Enables and illegal are always forced to 0 so a don't-care can never
  // turn into a spurious write.
  localparam logic FILL = XPROP_ZERO ? 1'b0 : 1'bx;

  logic [6:0] op;
  ctrl_t      dec_d;
  ctrl_t      ctrl_q, ctrl_d;
  logic       valid_q, valid_d_nxt;

  assign op = instr_d[6:0];

  // Opcode decode into the control bundle and the D-stage immediate select.
  always_comb begin
    dec_d            = '0;
    dec_d.alu_src_a  = FILL;
    dec_d.alu_src_b  = FILL;
    dec_d.result_src = {2{FILL}};
    dec_d.alu_op     = {2{FILL}};
    dec_d.funct3     = instr_d[14:12];
    dec_d.funct7b5   = instr_d[30];
    imm_src_d        = IMM_I;
    unique case (op)
      OP_LOAD: begin
        dec_d.reg_write  = 1'b1;
        dec_d.alu_src_a  = 1'b0;
        dec_d.alu_src_b  = 1'b1;
        dec_d.result_src = 2'b01;
        dec_d.alu_op     = 2'b00;
        imm_src_d        = IMM_I;
      end
      OP_STORE: begin
        dec_d.mem_write  = 1'b1;
        dec_d.alu_src_a  = 1'b0;
        dec_d.alu_src_b  = 1'b1;
        dec_d.alu_op     = 2'b00;
        imm_src_d        = IMM_S;
      end
      OP_RTYPE: begin
        dec_d.reg_write  = 1'b1;
        dec_d.alu_src_a  = 1'b0;
        dec_d.alu_src_b  = 1'b0;
        dec_d.result_src = 2'b00;
        dec_d.alu_op     = 2'b10;
      end
      OP_IALU: begin
        dec_d.reg_write  = 1'b1;
        dec_d.alu_src_a  = 1'b0;
        dec_d.alu_src_b  = 1'b1;
        dec_d.result_src = 2'b00;
        dec_d.alu_op     = 2'b10;
        imm_src_d        = IMM_I;
      end
      OP_BRANCH: begin
        dec_d.branch     = 1'b1;
        dec_d.alu_src_a  = 1'b0;
        dec_d.alu_src_b  = 1'b0;
        dec_d.alu_op     = 2'b01;
        imm_src_d        = IMM_B;
      end
      OP_JAL: begin
        dec_d.reg_write  = 1'b1;
        dec_d.jump       = 1'b1;
        dec_d.result_src = 2'b10;
        imm_src_d        = IMM_J;
      end
      OP_JALR: begin
        dec_d.reg_write  = 1'b1;
        dec_d.jalr       = 1'b1;
        dec_d.alu_src_a  = 1'b0;
        dec_d.alu_src_b  = 1'b1;
        dec_d.result_src = 2'b10;
        dec_d.alu_op     = 2'b00;
        imm_src_d        = IMM_I;
      end
      OP_LUI: begin
        dec_d.reg_write  = 1'b1;
        dec_d.result_src = 2'b11;
        imm_src_d        = IMM_U;
      end
      OP_AUIPC: begin
        dec_d.reg_write  = 1'b1;
        dec_d.alu_src_a  = 1'b1;
        dec_d.alu_src_b  = 1'b1;
        dec_d.result_src = 2'b00;
        dec_d.alu_op     = 2'b00;
        imm_src_d        = IMM_U;
      end
      OP_FENCE: begin
        // Legal NOP: all enables stay 0.
      end
      default: begin
        // Covers instr_d[1:0] != 2'b11 too, since every listed op ends in 11.
        dec_d.illegal    = 1'b1;
      end
    endcase
  end

  // Next E-stage contents: flush beats stall, stall holds, bubbles load zeros.
  always_comb begin
    ctrl_d      = ctrl_q;
    valid_d_nxt = valid_q;
    if (flush_e) begin
      ctrl_d      = '0;
      valid_d_nxt = 1'b0;
    end else if (!stall_e) begin
      valid_d_nxt = valid_d;
      ctrl_d      = valid_d ? dec_d : '0;
    end
  end

  // E-stage register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      ctrl_q  <= ctrl_d;
      valid_q <= valid_d_nxt;
    end
  end

  assign valid_e      = valid_q;
  assign reg_write_e  = ctrl_q.reg_write;
  assign mem_write_e  = ctrl_q.mem_write;
  assign branch_e     = ctrl_q.branch;
  assign jump_e       = ctrl_q.jump;
  assign jalr_e       = ctrl_q.jalr;
  assign alu_src_a_e  = ctrl_q.alu_src_a;
  assign alu_src_b_e  = ctrl_q.alu_src_b;
  assign illegal_e    = ctrl_q.illegal;
  assign result_src_e = ctrl_q.result_src;
  assign alu_op_e     = ctrl_q.alu_op;
  assign funct3_e     = ctrl_q.funct3;
  assign funct7b5_e   = ctrl_q.funct7b5;

`ifdef CTRL_ILL_CNT_EN
  logic [ILL_CNT_W-1:0] ill_cnt_q, ill_cnt_d;
  logic                 ill_inc;

  // Count only real illegal instructions actually loaded, saturating at all ones.
  always_comb begin
    ill_inc   = !flush_e && !stall_e && valid_d && dec_d.illegal && (ill_cnt_q != '1);
    ill_cnt_d = ill_inc ? ill_cnt_q + 1'b1 : ill_cnt_q;
  end

  // Illegal-instruction counter register.
  always_ff @(posedge clk) begin
    if (rst) ill_cnt_q <= '0;
    else     ill_cnt_q <= ill_cnt_d;
  end

  assign ill_cnt = ill_cnt_q;
`endif

endmodule

// File: tb/tb_ctrl_decode_pipe.sv
// tb_ctrl_decode_pipe: randomized and directed checks of ctrl_decode_pipe
// against a table-driven reference model of the E-stage pipeline.
module tb_ctrl_decode_pipe;

  localparam int TB_ILL_W = 2;
  localparam int ILL_MAX  = (1 << TB_ILL_W) - 1;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr_d;
  logic        valid_d, stall_e, flush_e;
  logic [2:0]  imm_src_d;
  logic        valid_e, reg_write_e, mem_write_e, branch_e, jump_e, jalr_e;
  logic        alu_src_a_e, alu_src_b_e, illegal_e, funct7b5_e;
  logic [1:0]  result_src_e, alu_op_e;
  logic [2:0]  funct3_e;
`ifdef CTRL_ILL_CNT_EN
  logic [TB_ILL_W-1:0] ill_cnt;
`endif

  int n_chk = 0;
  int n_err = 0;

  // Reference state: expected E-stage vector and counter value.
  logic [16:0] exp_e;
  int          exp_cnt;

  always #5 clk = ~clk;

  ctrl_decode_pipe #(.ILL_CNT_W(TB_ILL_W), .XPROP_ZERO(1'b1)) dut (
    .clk(clk), .rst(rst), .instr_d(instr_d), .valid_d(valid_d),
    .stall_e(stall_e), .flush_e(flush_e), .imm_src_d(imm_src_d),
    .valid_e(valid_e), .reg_write_e(reg_write_e), .mem_write_e(mem_write_e),
    .branch_e(branch_e), .jump_e(jump_e), .jalr_e(jalr_e),
    .alu_src_a_e(alu_src_a_e), .alu_src_b_e(alu_src_b_e),
    .illegal_e(illegal_e), .result_src_e(result_src_e), .alu_op_e(alu_op_e),
    .funct3_e(funct3_e),
`ifdef CTRL_ILL_CNT_EN
    .ill_cnt(ill_cnt),
`endif
    .funct7b5_e(funct7b5_e)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Opcode table: {reg_write,mem_write,branch,jump,jalr,alu_a,alu_b,
  //                result_src[1:0],alu_op[1:0],imm[2:0],illegal}
  function automatic logic [14:0] ref_dec(input logic [6:0] op);
    case (op)
      7'b0000011: return 15'b1000001_01_00_000_0;
      7'b0100011: return 15'b0100001_00_00_001_0;
      7'b0110011: return 15'b1000000_00_10_000_0;
      7'b0010011: return 15'b1000001_00_10_000_0;
      7'b1100011: return 15'b0010000_00_01_010_0;
      7'b1101111: return 15'b1001000_10_00_011_0;
      7'b1100111: return 15'b1000101_10_00_000_0;
      7'b0110111: return 15'b1000000_11_00_100_0;
      7'b0010111: return 15'b1000011_00_00_100_0;
      7'b0001111: return 15'b0000000_00_00_000_0;
      default:    return 15'b0000000_00_00_000_1;
    endcase
  endfunction

  function automatic logic [16:0] act_vec();
    return {valid_e, reg_write_e, mem_write_e, branch_e, jump_e, jalr_e,
            alu_src_a_e, alu_src_b_e, result_src_e, alu_op_e, illegal_e,
            funct3_e, funct7b5_e};
  endfunction

  // Apply one cycle of inputs, check imm_src_d combinationally, then advance
  // the reference model and compare the registered outputs after the edge.
  task automatic cycle(input logic [31:0] ins, input logic v, input logic st,
                       input logic fl, input logic r);
    logic [14:0] d;
    instr_d = ins; valid_d = v; stall_e = st; flush_e = fl; rst = r;
    d = ref_dec(ins[6:0]);
    #2;
    chk("imm_src_d", {29'd0, imm_src_d}, {29'd0, d[3:1]});
    @(posedge clk);
    if (r) begin
      exp_e = '0; exp_cnt = 0;
    end else if (fl) begin
      exp_e = '0;
    end else if (!st) begin
      if (v) begin
        exp_e = {1'b1, d[14:8], d[7:6], d[5:4], d[0], ins[14:12], ins[30]};
        if (d[0] && exp_cnt < ILL_MAX) exp_cnt++;
      end else begin
        exp_e = '0;
      end
    end
    #1;
    chk("e_bundle", {15'd0, act_vec()}, {15'd0, exp_e});
`ifdef CTRL_ILL_CNT_EN
    chk("ill_cnt", {{(32-TB_ILL_W){1'b0}}, ill_cnt}, exp_cnt);
`endif
  endtask

  logic [6:0] ops [10] = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
                           7'b1100011, 7'b1101111, 7'b1100111, 7'b0110111,
                           7'b0010111, 7'b0001111};

  initial begin
    int exp_sat [5] = '{1, 2, 3, 3, 3};
    logic [31:0] ins;
    int sel;
    rst = 1'b1; instr_d = '0; valid_d = 1'b0; stall_e = 1'b0; flush_e = 1'b0;
    exp_e = '0; exp_cnt = 0;
    @(posedge clk); #1;

    // Reset state, held over two edges.
    cycle(32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b1);
    cycle(32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("rst_outputs", {15'd0, act_vec()}, 32'd0);

    // addi
    cycle(32'h00A0_0093, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("addi_alu_op", {30'd0, alu_op_e}, 32'd2);
    chk("addi_reg_write", {31'd0, reg_write_e}, 32'd1);

    // lui
    cycle(32'h1234_52B7, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("lui_result_src", {30'd0, result_src_e}, 32'd3);

    // jalr then three stalled cycles with different instructions.
    cycle(32'h0000_80E7, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cycle($urandom, 1'b1, 1'b1, 1'b0, 1'b0);
      chk("stall_jalr", {31'd0, jalr_e}, 32'd1);
      chk("stall_result_src", {30'd0, result_src_e}, 32'd2);
    end

    // Flush with stall on a valid store.
    cycle(32'h0011_2023, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("flush_valid", {31'd0, valid_e}, 32'd0);
    chk("flush_mem_write", {31'd0, mem_write_e}, 32'd0);

    // Five illegal loads, then a stalled illegal cycle.
    for (int i = 0; i < 5; i++) begin
      cycle(32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("illegal_e", {31'd0, illegal_e}, 32'd1);
`ifdef CTRL_ILL_CNT_EN
      chk("ill_cnt_seq", {30'd0, ill_cnt}, exp_sat[i]);
`endif
    end
    cycle(32'hFFFF_FFFF, 1'b1, 1'b1, 1'b0, 1'b0);

    // Branch loaded, then reset the next cycle.
    cycle(32'h0020_8463, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("branch_e", {31'd0, branch_e}, 32'd1);
    cycle(32'h0000_0033, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("rst_after_branch", {15'd0, act_vec()}, 32'd0);
`ifdef CTRL_ILL_CNT_EN
    chk("rst_ill_cnt", {30'd0, ill_cnt}, 32'd0);
`endif

    // Random traffic, including resets during stall and flush.
    for (int n = 0; n < 2000; n++) begin
      ins = $urandom;
      sel = $urandom_range(0, 12);
      if (sel < 10) ins[6:0] = ops[sel];
      cycle(ins, $urandom_range(0, 9) != 0, $urandom_range(0, 4) == 0,
            $urandom_range(0, 9) == 0, $urandom_range(0, 39) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/ctrl_decode_pipe.md
CTRL_DECODE_PIPE -- requirements
Module: ctrl_decode_pipe

Interface
REQ-001 Parameter ILL_CNT_W, default 8, width of the illegal-instruction counter (legal range 1..32).
REQ-002 Parameter XPROP_ZERO, default 1; 1 drives decode fields that do not apply to an opcode to 0, 0 leaves them unspecified.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 instr_d  input  32  instruction in the decode stage.
REQ-006 valid_d  input  1  instr_d holds a real instruction; 0 means bubble.
REQ-007 stall_e  input  1  hold the E register.
REQ-008 flush_e  input  1  load a bubble into the E register.
REQ-009 imm_src_d  output  3  combinational immediate select for the D-stage extender: 000 I, 001 S, 010 B, 011 J, 100 U.
REQ-010 valid_e, reg_write_e, mem_write_e, branch_e, jump_e, jalr_e, alu_src_a_e, alu_src_b_e, illegal_e  output  1 each  registered E-stage controls.
REQ-011 result_src_e  output  2  registered result select: 00 ALU, 01 memory, 10 PC+4, 11 immediate.
REQ-012 alu_op_e  output  2  registered ALU op class: 00 add, 01 branch compare, 10 funct3/funct7 decode.
REQ-013 funct3_e  output  3  and funct7b5_e  output  1  registered copies of instr_d[14:12] and instr_d[30].
REQ-014 ill_cnt  output  ILL_CNT_W  illegal-instruction counter; present only under CTRL_ILL_CNT_EN.

Function
REQ-015 Decode SHALL use op = instr_d[6:0]; instr_d[1:0] != 11 or an unlisted op SHALL be illegal.
REQ-016 Load 0000011: reg_write 1, alu_src_b 1, result_src 01, imm I, alu_op 00.
REQ-017 Store 0100011: mem_write 1, alu_src_b 1, imm S, alu_op 00.
REQ-018 R-type 0110011: reg_write 1, alu_src_b 0, result_src 00, alu_op 10.
REQ-019 I-ALU 0010011: reg_write 1, alu_src_b 1, result_src 00, imm I, alu_op 10.
REQ-020 Branch 1100011: branch 1, alu_src_b 0, imm B, alu_op 01.
REQ-021 JAL 1101111: reg_write 1, jump 1, result_src 10, imm J.
REQ-022 JALR 1100111: reg_write 1, jalr 1, alu_src_b 1, result_src 10, imm I, alu_op 00.
REQ-023 LUI 0110111: reg_write 1, result_src 11, imm U.
REQ-024 AUIPC 0010111: reg_write 1, alu_src_a 1 (PC), alu_src_b 1, result_src 00, imm U, alu_op 00.
REQ-025 FENCE 0001111 SHALL be legal and decode as a NOP with all enables 0.
REQ-026 An illegal op SHALL force reg_write, mem_write, branch, jump and jalr to 0 and set illegal to 1.
REQ-027 Signals not listed for an op SHALL be 0 when XPROP_ZERO=1.
REQ-028 imm_src_d SHALL be 000 for ops without an immediate.
REQ-029 The E register SHALL update each cycle with priority rst > flush_e > stall_e > load.
REQ-030 Load: the E register SHALL capture the decoded bundle, with valid_e = valid_d, one cycle latency.
REQ-031 When valid_d=0 at load, the E register SHALL capture a bubble.
REQ-032 A bubble SHALL set valid_e and all enables, illegal_e and every multi-bit field to 0.
REQ-033 Stall: the E register SHALL hold all outputs unchanged.
REQ-034 Flush asserted together with stall_e: flush wins and the E register SHALL capture a bubble.

Reset
REQ-035 While rst is high at a clock edge, every E-stage output SHALL become 0 on that edge.
REQ-036 While rst is high at a clock edge, ill_cnt SHALL become 0 on that edge.
REQ-037 Reset mid-stall or mid-flush SHALL behave identically to REQ-035 and REQ-036.

Configuration
REQ-038 Macro CTRL_ILL_CNT_EN defined: ill_cnt SHALL exist.
REQ-039 ill_cnt SHALL increment by 1 on each load edge capturing valid_d=1 with an illegal op.
REQ-040 ill_cnt SHALL NOT increment during stall or flush.
REQ-041 ill_cnt SHALL saturate at all ones.
REQ-042 Macro CTRL_ILL_CNT_EN undefined: the ill_cnt port and its counter logic SHALL be absent, and all other behaviour SHALL be unchanged.

Verification
REQ-043 instr_d=0x00A00093 (addi), valid_d=1 -> next cycle: valid_e 1, reg_write_e 1, alu_src_b_e 1, alu_op_e 10, result_src_e 00; imm_src_d 000 same cycle.
REQ-044 instr_d=0x123452B7 (lui) -> imm_src_d 100; next cycle: result_src_e 11, reg_write_e 1.
REQ-045 instr_d=0x000080E7 (jalr) loaded, then stall_e=1 for 3 cycles with instr_d changed -> jalr_e 1 and result_src_e 10 held all 3 cycles.
REQ-046 stall_e=1 and flush_e=1 together with a valid store -> next cycle: valid_e 0, mem_write_e 0.
REQ-047 CTRL_ILL_CNT_EN, ILL_CNT_W=2: 5 valid loads of 0xFFFFFFFF -> illegal_e 1 each cycle and ill_cnt 1,2,3,3,3; a stalled illegal cycle leaves ill_cnt unchanged.
REQ-048 rst=1 in the cycle after a loaded branch -> all outputs 0 the following cycle; ill_cnt 0.
